// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults and helpers for the UART receive FIFO slice.
package uart_rx_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  // Largest value an error counter of the default width can hold.
  localparam int CNT_SAT_MAX_DEF = (1 << CNT_W_DEF) - 1;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// FIFO storage: register array with synchronous write and combinational read.
module uart_rx_fifo_mem #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: FWFT FIFO, sticky overflow,
// optional parity/stop error counters enabled by UART_RX_FIFO_ERR_CNT_EN.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          rx_p_data,
  input  logic                       rx_data_valid,
  input  logic                       rx_par_error,
  input  logic                       rx_stop_error,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [CNT_W-1:0]           par_err_cnt,
  output logic [CNT_W-1:0]           stop_err_cnt,
  input  logic                       cnt_clr
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic              dv_q;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              wr_ev, rd_take, wr_take, ovf_set, full;
  logic [DATA_W-1:0] mem_rdata;

  assign full    = (count_q == FULL_CNT);
  assign rd_valid = (count_q != '0);
  assign wr_ev   = rx_data_valid & ~dv_q;
  assign rd_take = rd_valid & rd_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign wr_take = wr_ev & (~full | rd_take);
  assign ovf_set = wr_ev & full & ~rd_take;

  // Stage: edge detect, pointers, occupancy and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q     <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      dv_q <= rx_data_valid;
      if (wr_take) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_take) rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({wr_take, rd_take})
        2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  uart_rx_fifo_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_take),
    .waddr (wr_ptr),
    .wdata (rx_p_data),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  assign fifo_count = count_q;
  // Masked so the read port shows 0 out of reset rather than stale storage.
  assign rd_data    = rd_valid ? mem_rdata : '0;

`ifdef UART_RX_FIFO_ERR_CNT_EN
  localparam logic [CNT_W-1:0] SAT_MAX = {CNT_W{1'b1}};

  logic             pe_q, se_q;
  logic             pe_ev, se_ev;
  logic [CNT_W-1:0] par_cnt_q, stop_cnt_q;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic ev,
                                                input logic clr);
    if (clr)                   return ev ? CNT_W'(1) : '0;
    if (ev && cur != SAT_MAX)  return cur + CNT_W'(1);
    return cur;
  endfunction

  assign pe_ev = rx_par_error & ~pe_q;
  assign se_ev = rx_stop_error & ~se_q;

  // Stage: error edge detect and saturating counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
      par_cnt_q  <= '0;
      stop_cnt_q <= '0;
    end else begin
      pe_q       <= rx_par_error;
      se_q       <= rx_stop_error;
      par_cnt_q  <= cnt_next(par_cnt_q, pe_ev, cnt_clr);
      stop_cnt_q <= cnt_next(stop_cnt_q, se_ev, cnt_clr);
    end
  end

  assign par_err_cnt  = par_cnt_q;
  assign stop_err_cnt = stop_cnt_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = ^{rx_par_error, rx_stop_error, cnt_clr};
  assign par_err_cnt  = '0;
  assign stop_err_cnt = '0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef UART_RX_FIFO_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              clk, rst_n;
  logic [DATA_W-1:0] rx_p_data;
  logic              rx_data_valid, rx_par_error, rx_stop_error;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid, rd_ready;
  logic [CW-1:0]     fifo_count;
  logic              overflow, ovf_clr, cnt_clr;
  logic [CNT_W-1:0]  par_err_cnt, stop_err_cnt;

  uart_rx_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_p_data     (rx_p_data),
    .rx_data_valid (rx_data_valid),
    .rx_par_error  (rx_par_error),
    .rx_stop_error (rx_stop_error),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .fifo_count    (fifo_count),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr),
    .par_err_cnt   (par_err_cnt),
    .stop_err_cnt  (stop_err_cnt),
    .cnt_clr       (cnt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  bit m_ovf;
  int m_par, m_stop;
  bit p_dv, p_pe, p_se;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_par = 0; m_stop = 0;
    p_dv = 0; p_pe = 0; p_se = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(fifo_count), q.size());
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk({tag, ".rd_data"}, 32'(rd_data), 32'(q[0]));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".par_cnt"}, 32'(par_err_cnt), CNT_EN ? m_par : 0);
    chk({tag, ".stop_cnt"}, 32'(stop_err_cnt), CNT_EN ? m_stop : 0);
  endtask

  function automatic int sat_step(input int cur, input bit ev, input bit clr);
    if (clr) return ev ? 1 : 0;
    if (ev && cur < CMAX) return cur + 1;
    return cur;
  endfunction

  // One clock: apply inputs, advance the model on the edge, then check outputs.
  task automatic cycle(input string tag, input bit dv, input logic [DATA_W-1:0] d,
                       input bit pe, input bit se, input bit rdy,
                       input bit oclr, input bit cclr);
    bit wev, pev, sev, rd_t, was_full;
    rx_data_valid = dv; rx_p_data = d; rx_par_error = pe; rx_stop_error = se;
    rd_ready = rdy; ovf_clr = oclr; cnt_clr = cclr;
    wev = dv & ~p_dv; pev = pe & ~p_pe; sev = se & ~p_se;
    rd_t = rdy && (q.size() > 0);
    was_full = (q.size() == DEPTH);
    @(posedge clk);
    if (rd_t) void'(q.pop_front());
    if (wev) begin
      if (!was_full || rd_t) q.push_back(d);
      else m_ovf = 1;
    end
    if (!(wev && was_full && !rd_t) && oclr) m_ovf = 0;
    m_par  = sat_step(m_par, pev, cclr);
    m_stop = sat_step(m_stop, sev, cclr);
    p_dv = dv; p_pe = pe; p_se = se;
    #1;
    check_all(tag);
  endtask

  task automatic good(input string tag, input logic [DATA_W-1:0] d, input bit rdy);
    cycle(tag, 1, d, 0, 0, rdy, 0, 0);
    cycle(tag, 0, d, 0, 0, 0, 0, 0);
  endtask

  task automatic idle(input string tag, input bit rdy);
    cycle(tag, 0, '0, 0, 0, rdy, 0, 0);
  endtask

  initial begin
    rst_n = 0; rx_p_data = '0; rx_data_valid = 0; rx_par_error = 0;
    rx_stop_error = 0; rd_ready = 0; ovf_clr = 0; cnt_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset.rd_data", 32'(rd_data), 0);
    check_all("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // Basic FWFT ordering
    good("basic", 8'hA5, 0);
    good("basic", 8'h3C, 0);
    good("basic", 8'hFF, 0);
    chk("basic.count3", 32'(fifo_count), 3);
    chk("basic.head", 32'(rd_data), 32'hA5);
    idle("basic.rd", 1);
    chk("basic.second", 32'(rd_data), 32'h3C);
    idle("basic.rd", 1);
    chk("basic.third", 32'(rd_data), 32'hFF);
    idle("basic.rd", 1);
    chk("basic.empty", 32'(rd_valid), 0);
    idle("basic.rd_empty", 1);

    // Overflow on the ninth frame
    for (int i = 1; i <= 9; i++) good("ovf", 8'(i), 0);
    chk("ovf.count", 32'(fifo_count), DEPTH);
    chk("ovf.flag", 32'(overflow), 1);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf.order", 32'(rd_data), i);
      idle("ovf.rd", 1);
    end
    chk("ovf.sticky", 32'(overflow), 1);
    cycle("ovf.clr", 0, '0, 0, 0, 0, 1, 0);
    chk("ovf.cleared", 32'(overflow), 0);

    // Full FIFO with simultaneous write and read
    for (int i = 0; i < DEPTH; i++) good("full", 8'(8'h10 + i), 0);
    cycle("full.wr_rd", 1, 8'h77, 0, 0, 1, 0, 0);
    chk("full.count", 32'(fifo_count), DEPTH);
    chk("full.noovf", 32'(overflow), 0);
    idle("full", 0);
    for (int i = 0; i < DEPTH - 1; i++) idle("full.drain", 1);
    chk("full.last", 32'(rd_data), 32'h77);
    idle("full.drain", 1);

    // Error frames with flags held several cycles
    for (int f = 0; f < 3; f++) begin
      for (int c = 0; c < 4; c++) cycle("err", 0, 8'hEE, f < 2, f == 2, 0, 0, 0);
      idle("err", 0);
    end
    chk("err.nowrite", 32'(fifo_count), 0);
    chk("err.par", 32'(par_err_cnt), CNT_EN ? 2 : 0);
    chk("err.stop", 32'(stop_err_cnt), CNT_EN ? 1 : 0);

    // Saturation and clear-with-event
    cycle("sat.clr", 0, '0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      cycle("sat", 0, '0, 1, 0, 0, 0, 0);
      cycle("sat", 0, '0, 0, 0, 0, 0, 0);
    end
    chk("sat.par", 32'(par_err_cnt), CNT_EN ? CMAX : 0);
    cycle("sat.clr_ev", 0, '0, 1, 0, 0, 0, 1);
    chk("sat.clr_ev", 32'(par_err_cnt), CNT_EN ? 1 : 0);
    chk("sat.clr_stop", 32'(stop_err_cnt), 0);
    idle("sat", 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom),
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 31) == 0);
    end
    for (int i = 0; i < DEPTH + 1; i++) idle("rand.drain", 1);

    // Asynchronous reset mid-operation with the strobe held high
    for (int i = 0; i < 5; i++) good("rst.fill", 8'(8'h40 + i), 0);
    chk("rst.pre", 32'(fifo_count), 5);
    rx_data_valid = 1; rx_p_data = 8'h5A;
    #2;
    rst_n = 0;
    #1;
    model_reset();
    chk("rst.async.rd_data", 32'(rd_data), 0);
    check_all("rst.async");
    @(posedge clk); #1;
    check_all("rst.hold");
    rst_n = 1;
    cycle("rst.rel", 1, 8'h5A, 0, 0, 0, 0, 0);
    chk("rst.one_write", 32'(fifo_count), 1);
    cycle("rst.held", 1, 8'h5A, 0, 0, 0, 0, 0);
    cycle("rst.held", 1, 8'h5A, 0, 0, 0, 0, 0);
    chk("rst.still_one", 32'(fifo_count), 1);
    chk("rst.data", 32'(rd_data), 32'h5A);
    idle("rst.end", 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
